// File: rtl/quant_pkg.sv
// Shared definitions for the quantize/dequantize datapath: fp32 field layout,
// special-value constants and the scale classification used by both directions.
package quant_pkg;

  localparam int FP32_W        = 32;
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MANT_MSB = 22;
  localparam int FP32_MANT_W   = 23;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF    = 32'h7F80_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  localparam int Q_W = 8;

  typedef enum logic [1:0] {
    SCLS_NORMAL = 2'd0,
    SCLS_ZERO   = 2'd1,
    SCLS_INF    = 2'd2,
    SCLS_NAN    = 2'd3
  } scale_class_e;

  // Denormal scales are flushed to zero, so exp==0 alone selects SCLS_ZERO.
  function automatic scale_class_e classify_scale(input logic [31:0] s);
    scale_class_e c;
    if (s[FP32_EXP_MSB:FP32_EXP_LSB] == 8'h00) begin
      c = SCLS_ZERO;
    end else if (s[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_MAX) begin
      if (s[FP32_MANT_MSB:0] == 23'd0) begin
        c = SCLS_INF;
      end else begin
        c = SCLS_NAN;
      end
    end else begin
      c = SCLS_NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp32_norm_round.sv
// Combinational normalize/round/pack of an unsigned integer product whose leading
// one lies in bits 31..23, scaled by a biased fp32 exponent.
module fp32_norm_round
  import quant_pkg::*;
#(
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic [31:0] p_in,
  input  logic [7:0]  exp_in,
  input  logic        sign_in,
  output logic [31:0] fp_out,
  output logic        ovf
);

  logic [4:0]  lead_s;
  logic [30:0] norm_s;
  logic [22:0] mant_s;
  logic        guard_s;
  logic        sticky_s;
  logic        inc_s;
  logic [23:0] mant_inc_s;
  logic [22:0] mant_fin_s;
  logic [9:0]  exp_s;
  logic [9:0]  exp_fin_s;

  // Leading-one search, normalization, rounding and overflow packing.
  always_comb begin
    lead_s = 5'd23;
    for (int i = 23; i < 32; i++) begin
      lead_s = p_in[i] ? 5'(i) : lead_s;
    end
    // Left-align so the hidden one falls off the top; guard/sticky sit below the mantissa.
    norm_s   = 31'(p_in << (5'd31 - lead_s));
    mant_s   = norm_s[30:8];
    guard_s  = norm_s[7];
    sticky_s = |norm_s[6:0];
    exp_s    = {2'b00, exp_in} + {5'b00000, lead_s - 5'd23};

    if (ROUND_RNE) begin
      inc_s = guard_s & (sticky_s | mant_s[0]);
    end else begin
      inc_s = 1'b0;
    end

    mant_inc_s = {1'b0, mant_s} + {23'd0, inc_s};
    if (mant_inc_s[23]) begin
      mant_fin_s = 23'd0;
      exp_fin_s  = exp_s + 10'd1;
    end else begin
      mant_fin_s = mant_inc_s[22:0];
      exp_fin_s  = exp_s;
    end

    if (exp_fin_s >= 10'd255) begin
      fp_out = {sign_in, FP32_EXP_MAX, 23'd0};
      ovf    = 1'b1;
    end else begin
      fp_out = {sign_in, exp_fin_s[7:0], mant_fin_s};
      ovf    = 1'b0;
    end
  end

endmodule

// File: rtl/dequantize_pipeline.sv
// 8-bit quantized code to fp32: (q - zp) * scale (asym) or q * scale (sym).
// Input capture, integer-form, multiply and normalize/pack register stages.
module dequantize_pipeline
  import quant_pkg::*;
#(
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  q_in,
  input  logic [31:0] scale,
  input  logic [7:0]  zp,
  input  logic        use_asym,
  output logic [31:0] fp_out,
  output logic        out_valid,
  output logic        ovf,
  output logic        nan
);

  // Input capture
  logic         v0_r;
  logic [7:0]   q0_r;
  logic [31:0]  scale0_r;
  logic [7:0]   zp0_r;
  logic         asym0_r;

  // Integer form
  logic [8:0]   d_s;
  logic [8:0]   mag_s;
  logic         v1_r;
  logic         dsign1_r;
  logic [7:0]   mag1_r;
  logic         ssign1_r;
  logic [7:0]   sexp1_r;
  logic [22:0]  smant1_r;
  scale_class_e cls1_r;

  // Product
  logic [31:0]  prod_s;
  logic         v2_r;
  logic [31:0]  p2_r;
  logic         sign2_r;
  logic [7:0]   exp2_r;
  logic         zero2_r;
  scale_class_e cls2_r;

  // Pack
  logic [31:0]  nr_fp_s;
  logic         nr_ovf_s;
  logic [31:0]  res_fp_s;
  logic         res_ovf_s;
  logic         res_nan_s;
  logic         out_valid_r;
  logic [31:0]  fp_out_r;
  logic         ovf_r;
  logic         nan_r;

  // Capture inputs on ena; data may go stale while the valid bit is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r     <= 1'b0;
      q0_r     <= 8'd0;
      scale0_r <= 32'd0;
      zp0_r    <= 8'd0;
      asym0_r  <= 1'b0;
    end else begin
      v0_r <= ena;
      if (ena) begin
        q0_r     <= q_in;
        scale0_r <= scale;
        zp0_r    <= zp;
        asym0_r  <= use_asym;
      end
    end
  end

  // Signed difference and its magnitude; -255..255 fits a 9-bit two's complement.
  always_comb begin
    if (asym0_r) begin
      d_s = {1'b0, q0_r} - {1'b0, zp0_r};
    end else begin
      d_s = {q0_r[7], q0_r};
    end
    if (d_s[8]) begin
      mag_s = 9'd0 - d_s;
    end else begin
      mag_s = d_s;
    end
  end

  // Register sign/magnitude of d together with the split and classified scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      dsign1_r <= 1'b0;
      mag1_r   <= 8'd0;
      ssign1_r <= 1'b0;
      sexp1_r  <= 8'd0;
      smant1_r <= 23'd0;
      cls1_r   <= SCLS_NORMAL;
    end else begin
      v1_r     <= v0_r;
      dsign1_r <= d_s[8];
      mag1_r   <= mag_s[7:0];
      ssign1_r <= scale0_r[FP32_SIGN_BIT];
      sexp1_r  <= scale0_r[FP32_EXP_MSB:FP32_EXP_LSB];
      smant1_r <= scale0_r[FP32_MANT_MSB:0];
      cls1_r   <= classify_scale(scale0_r);
    end
  end

  assign prod_s = {24'd0, mag1_r} * {8'd0, 1'b1, smant1_r};

  // Register the 8x24 product, result sign, exponent and special-case class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      p2_r    <= 32'd0;
      sign2_r <= 1'b0;
      exp2_r  <= 8'd0;
      zero2_r <= 1'b0;
      cls2_r  <= SCLS_NORMAL;
    end else begin
      v2_r    <= v1_r;
      p2_r    <= prod_s;
      sign2_r <= dsign1_r ^ ssign1_r;
      exp2_r  <= sexp1_r;
      zero2_r <= (mag1_r == 8'd0);
      cls2_r  <= cls1_r;
    end
  end

  fp32_norm_round #(
    .ROUND_RNE (ROUND_RNE)
  ) u_norm_round (
    .p_in    (p2_r),
    .exp_in  (exp2_r),
    .sign_in (sign2_r),
    .fp_out  (nr_fp_s),
    .ovf     (nr_ovf_s)
  );

  // Special-case override in priority order: NaN scale, inf scale, zero, normal.
  always_comb begin
    res_fp_s  = 32'h0000_0000;
    res_ovf_s = 1'b0;
    res_nan_s = 1'b0;
    case (cls2_r)
      SCLS_NAN: begin
        res_fp_s  = FP32_QNAN;
        res_nan_s = 1'b1;
      end
      SCLS_INF: begin
        if (zero2_r) begin
          res_fp_s  = FP32_QNAN;
          res_nan_s = 1'b1;
        end else begin
          res_fp_s  = {sign2_r, FP32_EXP_MAX, 23'd0};
          res_ovf_s = 1'b1;
        end
      end
      SCLS_ZERO: begin
        res_fp_s = 32'h0000_0000;
      end
      SCLS_NORMAL: begin
        if (zero2_r) begin
          res_fp_s = 32'h0000_0000;
        end else begin
          res_fp_s  = nr_fp_s;
          res_ovf_s = nr_ovf_s;
        end
      end
      default: begin
        res_fp_s = 32'h0000_0000;
      end
    endcase
  end

  // Output register; flags are forced low on idle cycles, fp_out holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      fp_out_r    <= 32'h0000_0000;
      ovf_r       <= 1'b0;
      nan_r       <= 1'b0;
    end else if (v2_r) begin
      out_valid_r <= 1'b1;
      fp_out_r    <= res_fp_s;
      ovf_r       <= res_ovf_s;
      nan_r       <= res_nan_s;
    end else begin
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      nan_r       <= 1'b0;
    end
  end

  assign fp_out    = fp_out_r;
  assign out_valid = out_valid_r;
  assign ovf       = ovf_r;
  assign nan       = nan_r;

endmodule

// File: tb/tb_dequantize_pipeline.sv
// Randomized self-checking bench for dequantize_pipeline: one RNE and one truncating
// instance share stimulus and are scored against a real-arithmetic reference model.
module tb_dequantize_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  q_in;
  logic [31:0] scale;
  logic [7:0]  zp;
  logic        use_asym;

  logic [31:0] fp_rne, fp_tz;
  logic        vld_rne, vld_tz, ovf_rne, ovf_tz, nan_rne, nan_tz;

  always #5 clk = ~clk;

  dequantize_pipeline #(.ROUND_RNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .q_in(q_in), .scale(scale), .zp(zp),
    .use_asym(use_asym), .fp_out(fp_rne), .out_valid(vld_rne), .ovf(ovf_rne), .nan(nan_rne)
  );

  dequantize_pipeline #(.ROUND_RNE(1'b0)) dut_tz (
    .clk(clk), .rst_n(rst_n), .ena(ena), .q_in(q_in), .scale(scale), .zp(zp),
    .use_asym(use_asym), .fp_out(fp_tz), .out_valid(vld_tz), .ovf(ovf_tz), .nan(nan_tz)
  );

  typedef struct {
    int          due;
    logic [31:0] f_rne;
    logic [31:0] f_tz;
    logic        o_rne;
    logic        o_tz;
    logic        n;
  } exp_t;

  exp_t sbq[$];
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (edge %0d)", tag, obs, expv, edge_cnt);
    end
  endtask

  // Exact double product -> fp32 with optional round-to-nearest-even.
  function automatic void to_fp32(input real x, input bit rne,
                                  output logic [31:0] f, output logic o);
    logic [63:0] b;
    int          e;
    logic [23:0] m;
    logic        g, st;
    b  = $realtobits(x);
    e  = int'(b[62:52]) - 896;
    m  = {1'b0, b[51:29]};
    g  = b[28];
    st = |b[27:0];
    if (rne && g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    if (e >= 255) begin
      f = {b[63], 8'hFF, 23'd0};
      o = 1'b1;
    end else begin
      f = {b[63], e[7:0], m[22:0]};
      o = 1'b0;
    end
  endfunction

  function automatic void ref_model(input logic [7:0] q, input logic [31:0] s,
                                    input logic [7:0] z, input logic a, input bit rne,
                                    output logic [31:0] f, output logic o, output logic n);
    int  d;
    real sv;
    d = a ? (int'(q) - int'(z)) : int'($signed(q));
    f = 32'h0; o = 1'b0; n = 1'b0;
    if (s[30:23] == 8'hFF && s[22:0] != 23'd0) begin
      f = 32'h7FC0_0000; n = 1'b1;
    end else if (s[30:23] == 8'hFF) begin
      if (d == 0) begin
        f = 32'h7FC0_0000; n = 1'b1;
      end else begin
        f = {((d < 0) ? 1'b1 : 1'b0) ^ s[31], 8'hFF, 23'd0}; o = 1'b1;
      end
    end else if (d == 0 || s[30:23] == 8'h00) begin
      f = 32'h0;
    end else begin
      sv = $bitstoreal({s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'd0});
      to_fp32(real'(d) * sv, rne, f, o);
    end
  endfunction

  task automatic check_outputs();
    exp_t x;
    if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
      x = sbq.pop_front();
      chk("valid_rne", {31'd0, vld_rne}, 32'd1);
      chk("valid_tz",  {31'd0, vld_tz},  32'd1);
      chk("fp_rne",    fp_rne, x.f_rne);
      chk("fp_tz",     fp_tz,  x.f_tz);
      chk("ovf_rne",   {31'd0, ovf_rne}, {31'd0, x.o_rne});
      chk("ovf_tz",    {31'd0, ovf_tz},  {31'd0, x.o_tz});
      chk("nan_rne",   {31'd0, nan_rne}, {31'd0, x.n});
      chk("nan_tz",    {31'd0, nan_tz},  {31'd0, x.n});
    end else begin
      chk("idle_valid", {31'd0, vld_rne | vld_tz}, 32'd0);
      chk("idle_flags", {30'd0, ovf_rne | ovf_tz, nan_rne | nan_tz}, 32'd0);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] q, input logic [31:0] s,
                       input logic [7:0] z, input logic a, input exp_t x);
    exp_t y;
    ena = e; q_in = q; scale = s; zp = z; use_asym = a;
    @(posedge clk);
    edge_cnt++;
    if (e) begin
      y = x;
      y.due = edge_cnt + 3;
      sbq.push_back(y);
    end
    #1;
    check_outputs();
  endtask

  task automatic send_model(input logic [7:0] q, input logic [31:0] s,
                            input logic [7:0] z, input logic a);
    exp_t x;
    logic n2;
    ref_model(q, s, z, a, 1'b1, x.f_rne, x.o_rne, x.n);
    ref_model(q, s, z, a, 1'b0, x.f_tz, x.o_tz, n2);
    x.due = 0;
    drive(1'b1, q, s, z, a, x);
  endtask

  task automatic send_const(input logic [7:0] q, input logic [31:0] s, input logic [7:0] z,
                            input logic a, input logic [31:0] fr, input logic [31:0] ft,
                            input logic o, input logic n);
    exp_t x;
    x.due = 0; x.f_rne = fr; x.f_tz = ft; x.o_rne = o; x.o_tz = o; x.n = n;
    drive(1'b1, q, s, z, a, x);
  endtask

  task automatic idle();
    exp_t x;
    x.due = 0; x.f_rne = 32'h0; x.f_tz = 32'h0; x.o_rne = 1'b0; x.o_tz = 1'b0; x.n = 1'b0;
    drive(1'b0, 8'($urandom), $urandom, 8'($urandom), 1'($urandom), x);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fp"}, fp_rne | fp_tz, 32'h0);
    chk({tag, "_ctl"}, {26'd0, vld_rne, vld_tz, ovf_rne, ovf_tz, nan_rne, nan_tz}, 32'd0);
  endtask

  function automatic logic [31:0] rand_scale();
    logic [31:0] s;
    int          k;
    s = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0:       s[30:23] = 8'h00;
      1:       begin s[30:23] = 8'hFF; s[22:0] = 23'd0; end
      2:       begin s[30:23] = 8'hFF; s[22] = 1'b1; end
      3:       s[30:23] = 8'($urandom_range(246, 254));
      default: s[30:23] = 8'($urandom_range(1, 254));
    endcase
    return s;
  endfunction

  initial begin
    logic [7:0] rq, rz;
    rst_n = 1'b0; ena = 1'b0; q_in = 8'd0; scale = 32'd0; zp = 8'd0; use_asym = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed points with hand-derived results
    send_const(8'd35,  32'h3F00_0000, 8'd10, 1'b1, 32'h4148_0000, 32'h4148_0000, 1'b0, 1'b0);
    repeat (4) idle();
    send_const(8'h7F,  32'h3F80_0000, 8'd0,  1'b0, 32'h42FE_0000, 32'h42FE_0000, 1'b0, 1'b0);
    send_const(8'h80,  32'h3E80_0000, 8'd0,  1'b0, 32'hC200_0000, 32'hC200_0000, 1'b0, 1'b0);
    send_const(8'd5,   32'h3F80_0000, 8'd5,  1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    send_const(8'd3,   32'h3F80_0001, 8'd0,  1'b0, 32'h4040_0002, 32'h4040_0001, 1'b0, 1'b0);
    send_const(8'd4,   32'h7F00_0000, 8'd0,  1'b0, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0);
    send_const(8'd17,  32'h7FC0_0001, 8'd3,  1'b1, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0, 1'b1);
    send_const(8'd0,   32'h7F80_0000, 8'd0,  1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0, 1'b1);
    send_const(8'hFC,  32'h7F80_0000, 8'd0,  1'b0, 32'hFF80_0000, 32'hFF80_0000, 1'b1, 1'b0);
    send_const(8'h9,   32'h0000_0001, 8'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    send_const(8'd0,   32'h437F_0000, 8'd255, 1'b1, 32'hC77E_0100, 32'hC77E_0100, 1'b0, 1'b0);
    repeat (4) idle();

    // Back-to-back stream
    send_model(8'd10, 32'h3FC0_0000, 8'd0, 1'b0);
    send_model(8'd20, 32'h3FC0_0000, 8'd0, 1'b0);
    send_model(8'd30, 32'hBFC0_0000, 8'd7, 1'b1);
    send_model(8'd40, 32'h3DCC_CCCD, 8'd0, 1'b0);
    repeat (4) idle();

    // Reset with two items in flight
    send_model(8'd50, 32'h3F80_0000, 8'd0, 1'b0);
    send_model(8'd60, 32'h3F80_0000, 8'd0, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sbq.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs("inreset");
    end
    rst_n = 1'b1;
    repeat (6) idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        rq = 8'($urandom);
        rz = ($urandom_range(0, 7) == 0) ? rq : 8'($urandom);
        send_model(rq, rand_scale(), rz, 1'($urandom));
      end else begin
        idle();
      end
    end
    repeat (5) idle();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
